fb_scan_arbiter: RTL and testbench
==================================

Name: fb_scan_arbiter

Overview:
Shares one single-port, synchronous-read framebuffer RAM between two requesters: the VGA scan-out path and a CPU load/store port. The frame is 640x480 at 1 bpp, packed 8 pixels per byte, MSB = leftmost pixel, row-major and linear (80 words per line, 38400 words in total). The block prefetches display words ahead of the pixel stream, serialises them to a 1-bit pixel output, and gives every free RAM slot to the CPU. It sits between the VGA timing generator (pix_en, frame_start) and the framebuffer RAM.

Parameters:
ADDR_W, 16, RAM word address width
DATA_W, 8, RAM word width (= pixels per word)
FB_WORDS, 38400, number of words in one frame

Ports:
clk_25m  in  1  pixel clock
rst_n  in  1  asynchronous, active-low reset
frame_start  in  1  1-cycle pulse; arrives at least 8 cycles before the frame's first pix_en
pix_en  in  1  visible pixel this cycle; one pixel consumed per cycle
pix_out  out  1  pixel value, registered, valid the cycle after pix_en
underrun  out  1  sticky; set when a pixel was needed but no word was loaded
cpu_req  in  1  CPU request; cpu_we/addr/wdata held stable until cpu_ready
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  word address
cpu_wdata  in  DATA_W  write data
cpu_ready  out  1  accept pulse; RAM access issued this cycle
cpu_rvalid  out  1  1-cycle pulse, the cycle after a read's cpu_ready
cpu_rdata  out  DATA_W  read data, qualified by cpu_rvalid
ram_en  out  1  RAM access this cycle
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  read data, valid the cycle after ram_en && !ram_we

Behaviour:
- Reset: every output is 0. Internal state clears: scan_addr = 0, pf_valid = 0, sh_valid = 0, bit count = 0, rd_owner = NONE. No grants are issued while in reset.
- Arbitration (combinational each cycle, at most one RAM access per cycle):
  - disp_want = pf_valid == 0 && rd_owner != DISP && scan_addr < FB_WORDS && !frame_start.
  - disp_want has strict priority over cpu_req.
  - A granted display access drives ram_en = 1, ram_we = 0, ram_addr = scan_addr.
  - A granted CPU access drives ram_en, ram_we = cpu_we, ram_addr = cpu_addr, ram_wdata = cpu_wdata, and cpu_ready = 1.
  - The display needs at most 1 slot per 8 cycles, so the CPU is guaranteed at least 6 of every 8 slots during the visible area.
- Read tag: rd_owner (NONE/DISP/CPU) is registered at each read grant.
  - The next cycle, DISP data is captured into pf (pf_valid = 1) and scan_addr increments.
  - The next cycle, CPU data drives cpu_rdata and pulses cpu_rvalid.
- Out-of-range CPU access (cpu_addr >= FB_WORDS): still acknowledged; no RAM access is made. A write is dropped; a read returns cpu_rvalid with cpu_rdata = 0.
- Shifter (two registers: sh = current word, pf = next word):
  - When sh_valid == 0 and pf_valid == 1, pf moves to sh and clears pf_valid.
  - pix_en with sh_valid: pix_out <= sh MSB, sh shifts left, bit count increments. On count 7 -> 0, sh_valid clears; if pf_valid, pf loads into sh in that same cycle, with no bubble.
  - pix_en with !sh_valid: pix_out <= 0 and underrun <= 1.
  - Without pix_en: pix_out <= 0.
- Frame end: scan_addr saturates at FB_WORDS; no further display fetches until frame_start.
- frame_start (mid-frame allowed):
  - Clears scan_addr, pf_valid, sh_valid, bit count and underrun.
  - A display read in flight has its data discarded.
  - A CPU read in flight completes normally.
  - If pix_en coincides with frame_start, pix_en is ignored and underrun stays 0.
- Startup latency: the first word reaches sh 4 cycles after frame_start, and pf is valid by cycle 6.

Decomposition:
- Package fb_pkg:
  - FB_H = 640, FB_V = 480, PIX_PER_WORD = 8, FB_WORDS = 38400
  - owner enum {OWN_NONE, OWN_DISP, OWN_CPU}
- Sub-module fb_pixel_shifter: sh/pf registers, bit counter, pix_out, underrun. Interface: load strobe + data in, pf_valid out, pix_en, clear.

Test Plan:
- Reset: assert rst_n = 0 mid-activity -> all outputs 0 immediately; no ram_en until after release.
- Serialisation: RAM[0] = 8'hA5, RAM[1] = 8'h3C; frame_start, then pix_en high for 16 cycles starting 10 cycles later -> pix_out = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 (one cycle lag); underrun = 0; scan_addr fetches 0,1,2 in order.
- Contention: cpu_req write addr 5 data 8'hFF in the same cycle as disp_want -> display read granted first; cpu_ready the following cycle with ram_we = 1, ram_addr = 5, ram_wdata = 8'hFF.
- CPU read: RAM[100] = 8'h5A, cpu_req read addr 100 while idle -> cpu_ready that cycle; next cycle cpu_rvalid = 1, cpu_rdata = 8'h5A; no rvalid for display reads.
- Underrun/restart: pix_en 1 cycle after frame_start -> pix_out = 0, underrun = 1 and held; next frame_start -> underrun = 0.
- Boundaries:
  - cpu write addr 38400 -> cpu_ready pulses, ram_en stays 0.
  - After 38400 display fetches, no further display ram_en until frame_start.
  - frame_start during an in-flight display read -> data discarded, refetch starts at addr 0.

Source files
------------

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants and types for the framebuffer scan arbiter
//
// Purpose : frame geometry constants and the read-owner tag type.
// Ports   : none (package).

package fb_pkg;

  localparam int FB_H         = 640;
  localparam int FB_V         = 480;
  localparam int PIX_PER_WORD = 8;
  localparam int FB_WORDS     = FB_H * FB_V / PIX_PER_WORD;

  // Who issued the RAM read whose data arrives next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

endpackage

// File: rtl/fb_pixel_shifter.sv
// rtl/fb_pixel_shifter.sv - two-word display buffer and 1-bit pixel serialiser
//
// Purpose : holds the current display word (sh) and the prefetched next word
//           (pf), shifts one pixel out per pix_en, flags underrun.
// Ports   : clk_25m, rst_n      clock, async active-low reset
//           clear              frame restart; empties both words, clears underrun
//           load, load_data    write a fetched word into pf
//           pix_en             consume one pixel this cycle
//           pf_valid           pf holds a word (fetch is not wanted)
//           pix_out            registered pixel, valid the cycle after pix_en
//           underrun           sticky; pixel needed while sh was empty

module fb_pixel_shifter
  import fb_pkg::*;
#(
  parameter int DATA_W = PIX_PER_WORD
) (
  input  logic              clk_25m,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              pix_en,
  output logic              pf_valid,
  output logic              pix_out,
  output logic              underrun
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] sh, sh_nxt;
  logic [DATA_W-1:0] pf, pf_nxt;
  logic              sh_valid, sh_valid_nxt;
  logic              pf_valid_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              pix_nxt, underrun_nxt;

  always_comb begin
    sh_nxt       = sh;
    sh_valid_nxt = sh_valid;
    pf_nxt       = pf;
    pf_valid_nxt = pf_valid;
    cnt_nxt      = cnt;
    pix_nxt      = 1'b0;
    underrun_nxt = underrun;

    if (pix_en && sh_valid) begin
      pix_nxt = sh[DATA_W-1];
      sh_nxt  = {sh[DATA_W-2:0], 1'b0};
      cnt_nxt = cnt + 1'b1;
      if (cnt == CNT_LAST) begin
        // Last pixel of the word: hand over pf in the same cycle so the
        // pixel stream has no bubble at word boundaries.
        sh_valid_nxt = pf_valid;
        if (pf_valid) begin
          sh_nxt       = pf;
          pf_valid_nxt = 1'b0;
        end
      end
    end else begin
      if (pix_en) begin
        underrun_nxt = 1'b1;
      end
      if (!sh_valid && pf_valid) begin
        sh_nxt       = pf;
        sh_valid_nxt = 1'b1;
        pf_valid_nxt = 1'b0;
      end
    end

    // pf is only ever loaded while empty, so this never overwrites a word.
    if (load) begin
      pf_nxt       = load_data;
      pf_valid_nxt = 1'b1;
    end

    // Frame restart wins over everything, including a coincident pix_en.
    if (clear) begin
      sh_valid_nxt = 1'b0;
      pf_valid_nxt = 1'b0;
      cnt_nxt      = '0;
      pix_nxt      = 1'b0;
      underrun_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      sh       <= '0;
      pf       <= '0;
      sh_valid <= 1'b0;
      pf_valid <= 1'b0;
      cnt      <= '0;
      pix_out  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      sh       <= sh_nxt;
      pf       <= pf_nxt;
      sh_valid <= sh_valid_nxt;
      pf_valid <= pf_valid_nxt;
      cnt      <= cnt_nxt;
      pix_out  <= pix_nxt;
      underrun <= underrun_nxt;
    end
  end

endmodule

// File: rtl/fb_scan_arbiter.sv
// rtl/fb_scan_arbiter.sv - shares one framebuffer RAM between VGA scan-out and a CPU
//
// Purpose : prefetches display words ahead of the pixel stream, serialises
//           them to pix_out, and gives every free RAM slot to the CPU.
// Ports   : clk_25m, rst_n                 clock, async active-low reset
//           frame_start, pix_en            from the VGA timing generator
//           pix_out, underrun              pixel stream and sticky underrun flag
//           cpu_req/we/addr/wdata          CPU request, held until cpu_ready
//           cpu_ready, cpu_rvalid, cpu_rdata  CPU accept and read return
//           ram_en/we/addr/wdata, ram_rdata   single-port sync-read RAM

module fb_scan_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = fb_pkg::PIX_PER_WORD,
  parameter int FB_WORDS = fb_pkg::FB_WORDS
) (
  input  logic              clk_25m,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              pix_en,
  output logic              pix_out,
  output logic              underrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  import fb_pkg::*;

  localparam logic [ADDR_W-1:0] FB_LIM = ADDR_W'(FB_WORDS);

  logic [ADDR_W-1:0] scan_addr;
  owner_e            rd_owner;
  logic              rd_oor;
  logic              pf_valid;
  logic              disp_want, disp_grant, cpu_grant, cpu_hit, disp_load;

  // Display fetch is wanted only when the prefetch slot is empty and no
  // display read is already in flight; frame_start blocks it so the first
  // fetch of a frame always uses the cleared scan address.
  assign disp_want  = !pf_valid && (rd_owner != OWN_DISP) &&
                      (scan_addr < FB_LIM) && !frame_start;
  assign disp_grant = rst_n && disp_want;
  assign cpu_grant  = rst_n && cpu_req && !disp_want;
  assign cpu_hit    = cpu_addr < FB_LIM;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    cpu_ready = 1'b0;
    if (disp_grant) begin
      ram_en   = 1'b1;
      ram_addr = scan_addr;
    end else if (cpu_grant) begin
      cpu_ready = 1'b1;
      // Out-of-range requests are acknowledged without touching the RAM.
      if (cpu_hit) begin
        ram_en    = 1'b1;
        ram_we    = cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      scan_addr <= '0;
      rd_owner  <= OWN_NONE;
      rd_oor    <= 1'b0;
    end else begin
      if (disp_grant) begin
        rd_owner <= OWN_DISP;
      end else if (cpu_grant && !cpu_we) begin
        rd_owner <= OWN_CPU;
      end else begin
        rd_owner <= OWN_NONE;
      end
      rd_oor <= cpu_grant && !cpu_we && !cpu_hit;

      // scan_addr stops at FB_LIM because no fetch is wanted there.
      if (frame_start) begin
        scan_addr <= '0;
      end else if (rd_owner == OWN_DISP) begin
        scan_addr <= scan_addr + 1'b1;
      end
    end
  end

  // A display word returning in a frame_start cycle belongs to the old frame.
  assign disp_load  = (rd_owner == OWN_DISP) && !frame_start;
  assign cpu_rvalid = (rd_owner == OWN_CPU);
  assign cpu_rdata  = (cpu_rvalid && !rd_oor) ? ram_rdata : '0;

  fb_pixel_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .clk_25m   (clk_25m),
    .rst_n     (rst_n),
    .clear     (frame_start),
    .load      (disp_load),
    .load_data (ram_rdata),
    .pix_en    (pix_en),
    .pf_valid  (pf_valid),
    .pix_out   (pix_out),
    .underrun  (underrun)
  );

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// tb/tb_fb_scan_arbiter.sv - self-checking bench for fb_scan_arbiter

module tb_fb_scan_arbiter;

  logic        clk_25m = 1'b0;
  logic        rst_n;
  logic        frame_start, pix_en;
  logic        pix_out, underrun;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready, cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        ram_en, ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;

  // Second instance with a tiny frame so the end-of-frame boundary is reachable.
  logic        s_frame_start, s_pix_en;
  logic        s_pix_out, s_underrun, s_cpu_ready, s_cpu_rvalid;
  logic [7:0]  s_cpu_rdata;
  logic        s_ram_en, s_ram_we;
  logic [15:0] s_ram_addr;
  logic [7:0]  s_ram_wdata, s_ram_rdata;

  logic [7:0]  mem [0:65535];
  logic [7:0]  ref_mem [0:65535];

  bit          pix_q [$];
  logic [7:0]  cpu_q [$];
  logic [15:0] disp_log [$];
  logic [15:0] s_log [$];
  logic        pix_en_s;

  int n_chk  = 0;
  int n_pass = 0;

  always #20 clk_25m = ~clk_25m;

  fb_scan_arbiter dut (
    .clk_25m(clk_25m), .rst_n(rst_n), .frame_start(frame_start), .pix_en(pix_en),
    .pix_out(pix_out), .underrun(underrun), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  fb_scan_arbiter #(.FB_WORDS(4)) dut_small (
    .clk_25m(clk_25m), .rst_n(rst_n), .frame_start(s_frame_start), .pix_en(s_pix_en),
    .pix_out(s_pix_out), .underrun(s_underrun), .cpu_req(1'b0), .cpu_we(1'b0),
    .cpu_addr(16'h0000), .cpu_wdata(8'h00), .cpu_ready(s_cpu_ready),
    .cpu_rvalid(s_cpu_rvalid), .cpu_rdata(s_cpu_rdata), .ram_en(s_ram_en),
    .ram_we(s_ram_we), .ram_addr(s_ram_addr), .ram_wdata(s_ram_wdata),
    .ram_rdata(s_ram_rdata)
  );

  always @(posedge clk_25m) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
    if (s_ram_en) s_ram_rdata <= 8'hFF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Mid-cycle sampling: log RAM traffic and push expected CPU read data.
  task automatic half();
    @(negedge clk_25m);
    pix_en_s = pix_en;
    if (ram_en && !ram_we && !cpu_ready) disp_log.push_back(ram_addr);
    if (s_ram_en) s_log.push_back(s_ram_addr);
    if (cpu_req && cpu_ready) begin
      if (cpu_we) begin
        if (cpu_addr < 16'd38400) ref_mem[cpu_addr] = cpu_wdata;
      end else begin
        cpu_q.push_back(cpu_addr < 16'd38400 ? ref_mem[cpu_addr] : 8'h00);
      end
    end
  endtask

  // Just after the edge: compare registered outputs against the scoreboards.
  task automatic fin();
    @(posedge clk_25m);
    #1;
    if (pix_en_s) begin
      chk("pix_q_nonempty", pix_q.size() != 0, 1);
      if (pix_q.size() != 0) chk("pix_out", pix_out, pix_q.pop_front());
    end else begin
      chk("pix_idle", pix_out, 0);
    end
    if (cpu_rvalid) begin
      chk("rvalid_expected", cpu_q.size() != 0, 1);
      if (cpu_q.size() != 0) chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
    end
  endtask

  task automatic cyc();
    half();
    fin();
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int b = 7; b >= 0; b--) pix_q.push_back(w[b]);
  endtask

  // 16 pixels, one cycle each, expecting two words back to back.
  task automatic pix_run(input logic [7:0] w0, input logic [7:0] w1);
    push_word(w0);
    push_word(w1);
    pix_en = 1'b1;
    repeat (16) cyc();
    pix_en = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[100] = 8'h5A; mem[38400] = 8'h77;
    ref_mem[0] = 8'hA5; ref_mem[1] = 8'h3C; ref_mem[100] = 8'h5A;

    rst_n = 1'b0; frame_start = 1'b0; pix_en = 1'b0; pix_en_s = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd100; cpu_wdata = 8'h00;
    s_frame_start = 1'b0; s_pix_en = 1'b0;

    // Reset: no grants and all outputs low, even with a pending request.
    repeat (2) begin
      @(negedge clk_25m);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_cpu_ready", cpu_ready, 0);
      chk("rst_outs", {pix_out, underrun, cpu_rvalid, cpu_rdata, ram_addr}, 0);
    end
    cpu_req = 1'b0;
    @(posedge clk_25m); #1 rst_n = 1'b1;
    repeat (6) cyc();

    // Serialisation of two words and fetch order.
    disp_log.delete();
    pulse_fs();
    repeat (9) cyc();
    pix_run(8'hA5, 8'h3C);
    cyc();
    chk("ser_underrun", underrun, 0);
    chk("ser_fetch_cnt", disp_log.size() >= 3, 1);
    chk("ser_fetch0", disp_log[0], 16'd0);
    chk("ser_fetch1", disp_log[1], 16'd1);
    chk("ser_fetch2", disp_log[2], 16'd2);

    // Contention: display wins first, CPU write goes the next cycle.
    pulse_fs();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd5; cpu_wdata = 8'hFF;
    half();
    chk("cont_disp_en", {ram_en, ram_we, cpu_ready}, 3'b100);
    chk("cont_disp_addr", ram_addr, 16'd0);
    fin();
    half();
    chk("cont_cpu_ctl", {ram_en, ram_we, cpu_ready}, 3'b111);
    chk("cont_cpu_addr", ram_addr, 16'd5);
    chk("cont_cpu_wdata", ram_wdata, 8'hFF);
    fin();
    cpu_req = 1'b0;
    repeat (10) cyc();

    // CPU reads while the display is idle.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd100;
    half();
    chk("rd_ready", {cpu_ready, ram_en, ram_we}, 3'b110);
    chk("rd_addr", ram_addr, 16'd100);
    fin();
    chk("rd_rvalid", cpu_rvalid, 1);
    cpu_req = 1'b0;
    cyc();
    chk("rd_rvalid_pulse", cpu_rvalid, 0);
    cpu_req = 1'b1; cpu_addr = 16'd5;
    cyc();
    cpu_req = 1'b0;
    cyc();
    chk("rd_q_drained", cpu_q.size(), 0);

    // Out-of-range CPU accesses are acknowledged without RAM traffic.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd38400; cpu_wdata = 8'h11;
    half();
    chk("oor_wr", {cpu_ready, ram_en}, 2'b10);
    fin();
    cpu_we = 1'b0;
    half();
    chk("oor_rd", {cpu_ready, ram_en}, 2'b10);
    fin();
    chk("oor_rvalid", cpu_rvalid, 1);
    cpu_req = 1'b0;
    cyc();
    chk("oor_q_drained", cpu_q.size(), 0);

    // Underrun, its stickiness, and clearing by frame_start with pix_en ignored.
    pulse_fs();
    pix_en = 1'b1; pix_q.push_back(1'b0);
    cyc();
    pix_en = 1'b0;
    chk("ur_set", underrun, 1);
    repeat (5) cyc();
    chk("ur_held", underrun, 1);
    frame_start = 1'b1; pix_en = 1'b1; pix_q.push_back(1'b0);
    cyc();
    frame_start = 1'b0; pix_en = 1'b0;
    chk("ur_cleared", underrun, 0);

    // frame_start while the read of word 1 is in flight: refetch from 0.
    pulse_fs();
    repeat (3) cyc();
    half();
    chk("inflight_rd", {ram_en, ram_we, ram_addr}, {2'b10, 16'd1});
    fin();
    disp_log.delete();
    pulse_fs();
    repeat (9) cyc();
    pix_run(8'hA5, 8'h3C);
    chk("refetch0", disp_log[0], 16'd0);
    chk("refetch1", disp_log[1], 16'd1);
    chk("refetch_ur", underrun, 0);

    // End of frame on the small instance: exactly FB_WORDS fetches, then none.
    s_log.delete();
    s_frame_start = 1'b1; cyc(); s_frame_start = 1'b0;
    s_pix_en = 1'b1;
    repeat (60) cyc();
    s_pix_en = 1'b0;
    chk("end_fetch_cnt", s_log.size(), 4);
    chk("end_last_addr", s_log[3], 16'd3);
    repeat (10) cyc();
    chk("end_no_more", s_log.size(), 4);
    chk("end_underrun", s_underrun, 1);
    s_log.delete();
    s_frame_start = 1'b1; cyc(); s_frame_start = 1'b0;
    repeat (3) cyc();
    chk("end_restart", s_log[0], 16'd0);
    chk("end_restart_ur", s_underrun, 0);

    // Reset asserted mid-activity forces outputs low immediately.
    pulse_fs();
    pix_en = 1'b1; pix_q.push_back(1'b0);
    cyc();
    pix_en = 1'b0;
    chk("pre_rst_ur", underrun, 1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd100;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctl", {ram_en, cpu_ready, cpu_rvalid, underrun, pix_out}, 0);
    chk("arst_bus", {ram_addr, ram_wdata, cpu_rdata}, 0);
    @(negedge clk_25m);
    chk("arst_no_grant", {ram_en, cpu_ready}, 0);
    cpu_req = 1'b0;
    @(posedge clk_25m); #1 rst_n = 1'b1;
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
